// File: rtl/ppi_bus_pkg.sv
// Shared PPI bus definitions: state encoding, port addresses, control-word fields
// and bit set/reset command helpers used by both the host side and the PPI model.
package ppi_bus_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 2;

  typedef logic [1:0] state_t;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  localparam logic [ADDR_W-1:0] ADDR_PA  = 2'b00;
  localparam logic [ADDR_W-1:0] ADDR_PB  = 2'b01;
  localparam logic [ADDR_W-1:0] ADDR_PC  = 2'b10;
  localparam logic [ADDR_W-1:0] ADDR_CWR = 2'b11;

  // Control word fields; bit 7 clear means a bit set/reset command on port C
  localparam int unsigned CWR_MODE_SET_BIT = 7;
  localparam int unsigned CWR_MODE_MSB     = 6;
  localparam int unsigned CWR_MODE_LSB     = 5;
  localparam int unsigned CWR_PA_DIR_BIT   = 4;
  localparam int unsigned CWR_PCU_DIR_BIT  = 3;
  localparam int unsigned CWR_PB_DIR_BIT   = 1;
  localparam int unsigned CWR_PCL_DIR_BIT  = 0;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } ppi_req_t;

  function automatic logic [DATA_W-1:0] bsr_cmd(input logic [2:0] bit_sel, input logic set_bit);
    return {4'b0000, bit_sel, set_bit};
  endfunction

  function automatic logic is_bsr(input logic [DATA_W-1:0] cwr);
    return ~cwr[CWR_MODE_SET_BIT];
  endfunction

  function automatic logic [2:0] bsr_bit(input logic [DATA_W-1:0] cwr);
    return cwr[3:1];
  endfunction

endpackage

// File: rtl/ppi_bus_master.sv
// Host-side initiator turning single-beat valid/ready requests into PPI
// setup/strobe/hold bus cycles with a one-cycle response strobe.
module ppi_bus_master
  import ppi_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned HOLD_CYC  = 1,
  parameter int unsigned CNT_W     = 4
) (
  input  logic              clk,
  input  logic              int_reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              rdb,
  output logic              wrb,
  output logic              a1,
  output logic              a0,
  inout  wire  [DATA_W-1:0] data
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  ppi_req_t          req_q, req_d;
  logic              rdb_q, rdb_d;
  logic              wrb_q, wrb_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              drive_q, drive_d;
  logic              busy_q, busy_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              cnt_done;

  assign req_ready = (state_q == ST_IDLE) & ~int_reset;
  assign cnt_done  = (cnt_q == '0);

  // Next state, phase counter and response; bus pins follow the next state
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          req_d   = '{write: req_write, addr: req_addr, wdata: req_wdata};
          state_d = ST_SETUP;
          cnt_d   = CNT_W'(SETUP_CYC - 1);
        end
      end
      ST_SETUP: begin
        if (cnt_done) begin
          state_d = ST_STROBE;
          cnt_d   = CNT_W'(PULSE_CYC - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_STROBE: begin
        if (cnt_done) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_W'(HOLD_CYC - 1);
          // rdb is still low on this edge, so the PPI is still driving
          if (!req_q.write) rsp_rdata_d = data;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_done) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          if (req_q.write) rsp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d  = (state_d != ST_IDLE);
    drive_d = busy_d & req_d.write;
    addr_d  = busy_d ? req_d.addr : '0;
    rdb_d   = ~((state_d == ST_STROBE) & ~req_d.write);
    wrb_d   = ~((state_d == ST_STROBE) &  req_d.write);
  end

  always_ff @(posedge clk) begin
    if (int_reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      rdb_q       <= 1'b1;
      wrb_q       <= 1'b1;
      addr_q      <= '0;
      drive_q     <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      rdb_q       <= rdb_d;
      wrb_q       <= wrb_d;
      addr_q      <= addr_d;
      drive_q     <= drive_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign data      = drive_q ? req_q.wdata : {DATA_W{1'bz}};
  assign rdb       = rdb_q;
  assign wrb       = wrb_q;
  assign a1        = addr_q[1];
  assign a0        = addr_q[0];
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ppi_bus_master.sv
// Bench for ppi_bus_master with a small behavioural PPI responder on each bus.
module tb_ppi_bus_master;
  import ppi_bus_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       int_reset = 1'b1;
  logic       req_valid = 1'b0, req_valid2 = 1'b0;
  logic       req_write = 1'b0;
  logic [1:0] req_addr  = 2'b00;
  logic [7:0] req_wdata = 8'h00;

  logic       req_ready, rsp_valid, busy, rdb, wrb, a1, a0;
  logic [7:0] rsp_rdata;
  wire  [7:0] data;
  logic       req_ready2, rsp_valid2, busy2, rdb2, wrb2, a1_2, a0_2;
  logic [7:0] rsp_rdata2;
  wire  [7:0] data2;

  ppi_bus_master dut (
    .clk(clk), .int_reset(int_reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .rdb(rdb), .wrb(wrb), .a1(a1), .a0(a0), .data(data)
  );

  ppi_bus_master #(.SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2), .CNT_W(4)) dut2 (
    .clk(clk), .int_reset(int_reset), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .busy(busy2),
    .rdb(rdb2), .wrb(wrb2), .a1(a1_2), .a0(a0_2), .data(data2)
  );

  // PPI responder: ports latch on the wrb rising edge, reads drive while rdb is low
  logic [7:0] ppi_cwr = 8'h00, ppi_pa = 8'h00, ppi_pb = 8'h00, ppi_pc = 8'h00;
  logic [7:0] pa_in = 8'h00;
  logic [7:0] rd_val1, rd_val2, pb_view;

  always @(posedge wrb) begin
    case ({a1, a0})
      ADDR_PA: ppi_pa <= data;
      ADDR_PB: ppi_pb <= data;
      ADDR_PC: ppi_pc <= data;
      default: if (!is_bsr(data)) ppi_cwr <= data; else ppi_pc[bsr_bit(data)] <= data[0];
    endcase
  end

  always_comb begin
    case ({a1, a0})
      ADDR_PA: rd_val1 = pa_in;
      ADDR_PB: rd_val1 = ppi_pb;
      ADDR_PC: rd_val1 = ppi_pc;
      default: rd_val1 = ppi_cwr;
    endcase
    case ({a1_2, a0_2})
      ADDR_PA: rd_val2 = pa_in;
      ADDR_PB: rd_val2 = ppi_pb;
      ADDR_PC: rd_val2 = ppi_pc;
      default: rd_val2 = ppi_cwr;
    endcase
  end

  assign data    = !rdb  ? rd_val1 : 8'hzz;
  assign data2   = !rdb2 ? rd_val2 : 8'hzz;
  assign pb_view = (!wrb && {a1, a0} == ADDR_PB) ? data : ppi_pb;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic overlap_seen = 1'b0, rsp_wide = 1'b0, rsp_prev = 1'b0, rsp_prev2 = 1'b0;
  always @(negedge clk) begin
    if ((!rdb && !wrb) || (!rdb2 && !wrb2)) overlap_seen <= 1'b1;
    if ((rsp_valid && rsp_prev) || (rsp_valid2 && rsp_prev2)) rsp_wide <= 1'b1;
    rsp_prev  <= rsp_valid;
    rsp_prev2 <= rsp_valid2;
  end

  int n_tests = 0, n_fail = 0;
  logic [7:0] exp_q[$];

  // A released bus reads z, or 0 in two-state simulators
  function automatic bit released(input logic [7:0] v);
    return (v === 8'hzz) || (v === 8'h00);
  endfunction

  // Drives one request, pushes its expected response, observes the bus until rsp_valid
  task automatic run_txn(input bit sel, input logic wr, input logic [1:0] ad, input logic [7:0] wd,
                         input logic [7:0] exp_rd, output int lat, output int rdb_lo,
                         output int wrb_lo, output bit bus_ok, output logic [7:0] rd,
                         output logic [7:0] exp_pop, output logic [7:0] pb_seen);
    int acc, n;
    logic r, w, rv, b;
    logic [7:0] d;
    lat = -1; rdb_lo = 0; wrb_lo = 0; bus_ok = 1'b1; rd = 8'hEE; exp_pop = 8'hDD; pb_seen = 8'hEE;
    @(negedge clk);
    req_write = wr; req_addr = ad; req_wdata = wr ? wd : 8'hFF;
    if (sel) req_valid2 = 1'b1; else req_valid = 1'b1;
    n = 0;
    while (!(sel ? req_ready2 : req_ready) && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin req_valid = 1'b0; req_valid2 = 1'b0; return; end
    acc = cyc + 1;
    exp_q.push_back(exp_rd);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      req_valid = 1'b0; req_valid2 = 1'b0;
      r = sel ? rdb2 : rdb; w = sel ? wrb2 : wrb; rv = sel ? rsp_valid2 : rsp_valid;
      b = sel ? busy2 : busy; d = sel ? data2 : data;
      if (!r) rdb_lo++;
      if (!w) begin wrb_lo++; pb_seen = pb_view; end
      if (wr && b && d !== wd) bus_ok = 1'b0;
      if (!wr && r && !released(d)) bus_ok = 1'b0;
      if (rv) begin
        lat = cyc - acc + 1;
        rd = sel ? rsp_rdata2 : rsp_rdata;
        if (exp_q.size() > 0) exp_pop = exp_q.pop_front();
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if ({rdb, wrb, a1, a0} !== 4'b1100) begin n_fail++; $display("FAIL reset_pins: got %b expected 1100", {rdb, wrb, a1, a0}); end
    n_tests++; if ({busy, rsp_valid, req_ready} !== 3'b000) begin n_fail++; $display("FAIL reset_status: got %b expected 000", {busy, rsp_valid, req_ready}); end
    n_tests++; if (rsp_rdata !== 8'h00 || !released(data)) begin n_fail++; $display("FAIL reset_data: rdata %h data %h expected 00 and released", rsp_rdata, data); end
    int_reset = 1'b0;
    @(negedge clk);
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_read_pa();
    int lat, rl, wl; bit ok; logic [7:0] rd, ex, pbs;
    pa_in = 8'hA5;
    run_txn(1'b0, 1'b1, ADDR_CWR, 8'h9B, 8'h00, lat, rl, wl, ok, rd, ex, pbs);
    n_tests++; if (lat !== 5) begin n_fail++; $display("FAIL cwr9b_latency: got %0d expected 5", lat); end
    n_tests++; if (ppi_cwr !== 8'h9B) begin n_fail++; $display("FAIL cwr9b_captured: got %h expected 9b", ppi_cwr); end
    run_txn(1'b0, 1'b0, ADDR_PA, 8'h00, 8'hA5, lat, rl, wl, ok, rd, ex, pbs);
    n_tests++; if (rl !== 2 || wl !== 0) begin n_fail++; $display("FAIL pa_rd_strobes: rdb low %0d wrb low %0d expected 2 and 0", rl, wl); end
    n_tests++; if (rd !== ex) begin n_fail++; $display("FAIL pa_rd_rdata: got %h expected %h", rd, ex); end
    n_tests++; if (lat !== 5) begin n_fail++; $display("FAIL pa_rd_latency: got %0d expected 5", lat); end
    n_tests++; if (!ok) begin n_fail++; $display("FAIL pa_rd_bus_released: got driven expected released"); end
    repeat (3) @(negedge clk);
    n_tests++; if (rsp_rdata !== 8'hA5) begin n_fail++; $display("FAIL pa_rd_hold: got %h expected a5", rsp_rdata); end
  endtask

  task automatic test_write_pb();
    int lat, rl, wl; bit ok; logic [7:0] rd, ex, pbs;
    run_txn(1'b0, 1'b1, ADDR_CWR, 8'h80, 8'h00, lat, rl, wl, ok, rd, ex, pbs);
    n_tests++; if (ppi_cwr !== 8'h80) begin n_fail++; $display("FAIL cwr80_captured: got %h expected 80", ppi_cwr); end
    run_txn(1'b0, 1'b1, ADDR_PB, 8'h3C, 8'h00, lat, rl, wl, ok, rd, ex, pbs);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL pb_wr_data: got bus not 3c during busy expected 3c"); end
    n_tests++; if (wl !== 2 || rl !== 0) begin n_fail++; $display("FAIL pb_wr_strobes: wrb low %0d rdb low %0d expected 2 and 0", wl, rl); end
    n_tests++; if (pbs !== 8'h3C) begin n_fail++; $display("FAIL pb_wr_port: got %h expected 3c", pbs); end
    n_tests++; if (rd !== ex || lat !== 5) begin n_fail++; $display("FAIL pb_wr_rsp: rdata %h lat %0d expected %h and 5", rd, lat, ex); end
  endtask

  task automatic test_back_to_back();
    int a1c, a2c, n, nrsp, gap, hi, lat2;
    bit seen_low, rdy_at, early;
    logic [7:0] rd1, rd2, p1, p2;
    a2c = -1; nrsp = 0; gap = -1; hi = 0; lat2 = -1; seen_low = 0; rdy_at = 0; early = 0;
    rd1 = 8'hEE; rd2 = 8'hEE; p1 = 8'hDD; p2 = 8'hDD;
    @(negedge clk);
    req_write = 1'b1; req_addr = ADDR_PA; req_wdata = 8'h11; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    a1c = cyc + 1;
    exp_q.push_back(8'h00);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      req_wdata = 8'h22;
      if (a2c >= 0) req_valid = 1'b0;
      if (!wrb) begin
        if (seen_low && hi > 0 && gap < 0) gap = hi;
        seen_low = 1; hi = 0;
      end else if (seen_low) hi++;
      if (rsp_valid) begin
        nrsp++;
        if (nrsp == 1) begin
          rdy_at = req_ready; rd1 = rsp_rdata; p1 = exp_q.pop_front();
          a2c = cyc + 1; exp_q.push_back(8'h00);
        end else begin
          rd2 = rsp_rdata; p2 = exp_q.pop_front(); lat2 = cyc - a2c + 1;
          break;
        end
      end else if (nrsp == 0 && req_ready) early = 1;
    end
    req_valid = 1'b0;
    n_tests++; if (rdy_at !== 1'b1 || early) begin n_fail++; $display("FAIL b2b_accept_on_rsp: ready at rsp %b early %b expected 1 and 0", rdy_at, early); end
    n_tests++; if (a2c - a1c !== 5) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected 5", a2c - a1c); end
    n_tests++; if (gap < 3) begin n_fail++; $display("FAIL b2b_wrb_gap: got %0d expected >=3", gap); end
    n_tests++; if (rd1 !== p1 || rd2 !== p2 || lat2 !== 5) begin n_fail++; $display("FAIL b2b_rsp: %h %h lat %0d expected %h %h 5", rd1, rd2, lat2, p1, p2); end
    n_tests++; if (ppi_pa !== 8'h22) begin n_fail++; $display("FAIL b2b_pa: got %h expected 22", ppi_pa); end
  endtask

  task automatic test_reset_mid();
    int n;
    bit rsp_seen;
    @(negedge clk);
    req_write = 1'b1; req_addr = ADDR_PA; req_wdata = 8'h77; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (wrb && n < 20) begin @(negedge clk); n++; end
    n_tests++; if (wrb !== 1'b0) begin n_fail++; $display("FAIL rst_mid_reach_strobe: wrb got %b expected 0", wrb); end
    int_reset = 1'b1;
    @(negedge clk);
    n_tests++; if ({wrb, busy, rsp_valid, req_ready} !== 4'b1000) begin n_fail++; $display("FAIL rst_mid_pins: got %b expected 1000", {wrb, busy, rsp_valid, req_ready}); end
    n_tests++; if (!released(data)) begin n_fail++; $display("FAIL rst_mid_data: got %h expected released", data); end
    int_reset = 1'b0;
    rsp_seen = 0;
    @(negedge clk);
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b expected 1", req_ready); end
    for (int k = 0; k < 8; k++) begin
      if (rsp_valid) rsp_seen = 1;
      @(negedge clk);
    end
    n_tests++; if (rsp_seen) begin n_fail++; $display("FAIL rst_mid_no_rsp: got rsp_valid expected none"); end
  endtask

  task automatic test_params();
    int lat, rl, wl; bit ok; logic [7:0] rd, ex, pbs;
    run_txn(1'b1, 1'b0, ADDR_CWR, 8'h00, 8'h80, lat, rl, wl, ok, rd, ex, pbs);
    n_tests++; if (rl !== 3 || wl !== 0) begin n_fail++; $display("FAIL p232_strobes: rdb low %0d wrb low %0d expected 3 and 0", rl, wl); end
    n_tests++; if (lat !== 8) begin n_fail++; $display("FAIL p232_latency: got %0d expected 8", lat); end
    n_tests++; if (rd !== ex || !ok) begin n_fail++; $display("FAIL p232_rdata: got %h bus_ok %b expected %h and 1", rd, ok, ex); end
  endtask

  task automatic test_bsr();
    int lat, rl, wl; bit ok; logic [7:0] rd, ex, pbs;
    run_txn(1'b0, 1'b1, ADDR_CWR, bsr_cmd(3'd2, 1'b1), 8'h00, lat, rl, wl, ok, rd, ex, pbs);
    n_tests++; if (wl !== 2 || rl !== 0 || lat !== 5 || !ok) begin n_fail++; $display("FAIL bsr_wr_cycle: wrb %0d rdb %0d lat %0d ok %b expected 2 0 5 1", wl, rl, lat, ok); end
    n_tests++; if (ppi_pc !== 8'h04 || ppi_cwr !== 8'h80) begin n_fail++; $display("FAIL bsr_effect: pc %h cwr %h expected 04 80", ppi_pc, ppi_cwr); end
    run_txn(1'b0, 1'b0, ADDR_CWR, 8'h00, 8'h80, lat, rl, wl, ok, rd, ex, pbs);
    n_tests++; if (rd !== ex || rl !== 2) begin n_fail++; $display("FAIL bsr_cwr_rd: got %h rdb low %0d expected %h and 2", rd, rl, ex); end
    n_tests++; if (overlap_seen) begin n_fail++; $display("FAIL strobe_overlap: got rdb and wrb low together expected never"); end
    n_tests++; if (rsp_wide) begin n_fail++; $display("FAIL rsp_pulse_width: got >1 cycle expected 1"); end
  endtask

  initial begin
    test_reset();
    test_read_pa();
    test_write_pb();
    test_back_to_back();
    test_reset_mid();
    test_params();
    test_bsr();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
